// File: rtl/perf_pkg.sv
// Shared constants for the performance counter unit: counter slots, perf op
// encodings and the readout FSM state type.
package perf_pkg;

  localparam int unsigned NUM_CNT = 8;

  localparam logic [2:0] CNT_CYCLES  = 3'd0;
  localparam logic [2:0] CNT_RETIRED = 3'd1;
  localparam logic [2:0] CNT_ALU     = 3'd2;
  localparam logic [2:0] CNT_LOAD    = 3'd3;
  localparam logic [2:0] CNT_STORE   = 3'd4;
  localparam logic [2:0] CNT_BRANCH  = 3'd5;
  localparam logic [2:0] CNT_TAKEN   = 3'd6;
  localparam logic [2:0] CNT_JUMP    = 3'd7;

  typedef enum logic [1:0] {
    PERF_OP_READ     = 2'b00,
    PERF_OP_READ_CLR = 2'b01,
    PERF_OP_CLR_ALL  = 2'b10,
    PERF_OP_FREEZE   = 2'b11
  } perf_op_e;

  localparam logic [5:0] OPC_PERF = 6'b110011;

  typedef enum logic {
    StIdle,
    StHold
  } rd_state_e;

endpackage

// File: rtl/perf_event_counter.sv
// One saturating (or wrapping) event counter with a sticky overflow flag.
// A clear always wins over a same-cycle increment; hold freezes increments only.
module perf_event_counter #(
  parameter int unsigned CNT_W  = 32,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic             hold,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clr) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (inc && !hold) begin
      if (&count_q) begin
        sat_d   = 1'b1;
        count_d = SAT_EN ? count_q : '0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/perf_counter_unit.sv
// Event decode, perf-instruction servicing and the IDLE/HOLD snapshot readout
// for eight retired-instruction-class counters.
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic             jump,
  input  logic             branch,
  input  logic             branch_taken,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             perf,
  input  logic [1:0]       perf_op,
  input  logic [2:0]       perf_sel,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_data,
  output logic             out_sat,
  output logic             perf_overrun,
  output logic             frozen
);

  perf_op_e         op;
  logic             accept, cls_valid, rd_req, load, drop;
  logic [NUM_CNT-1:0] ev, clr, sat;
  logic [CNT_W-1:0] cnt [NUM_CNT];

  rd_state_e        state_q, state_d;
  logic [CNT_W-1:0] data_q, data_d;
  logic             osat_q, osat_d;
  logic             overrun_q, overrun_d;
  logic             frozen_q, frozen_d;

  assign op        = perf_op_e'(perf_op);
  assign accept    = perf & instr_valid;
  // The perf instruction itself only shows up in the cycle/retired counters.
  assign cls_valid = instr_valid & ~perf;
  assign rd_req    = accept & ((op == PERF_OP_READ) | (op == PERF_OP_READ_CLR));

  always_comb begin
    ev              = '0;
    ev[CNT_CYCLES]  = 1'b1;
    ev[CNT_RETIRED] = instr_valid;
    ev[CNT_ALU]     = cls_valid & reg_write & ~mem_read & ~jump;
    ev[CNT_LOAD]    = cls_valid & mem_read;
    ev[CNT_STORE]   = cls_valid & mem_write;
    ev[CNT_BRANCH]  = cls_valid & branch;
    ev[CNT_TAKEN]   = cls_valid & branch & branch_taken;
    ev[CNT_JUMP]    = cls_valid & jump;
  end

  always_comb begin
    clr = '0;
    if (accept) begin
      case (op)
        PERF_OP_CLR_ALL:  clr = '1;
        PERF_OP_READ_CLR: clr[perf_sel] = 1'b1;
        default:          clr = '0;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    perf_event_counter #(
      .CNT_W  (CNT_W),
      .SAT_EN (SAT_EN)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (ev[i]),
      .clr   (clr[i]),
      .hold  (frozen_q),
      .count (cnt[i]),
      .sat   (sat[i])
    );
  end

  // Readout FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Readout FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (rd_req) state_d = StHold;
      StHold:  if (out_ready && !rd_req) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Readout FSM: outputs
  always_comb begin
    out_valid = (state_q == StHold);
  end

  // A read is dropped only when a snapshot is still waiting for its handshake.
  assign load = rd_req & ((state_q == StIdle) | out_ready);
  assign drop = rd_req & (state_q == StHold) & ~out_ready;

  always_comb begin
    data_d    = load ? cnt[perf_sel] : data_q;
    osat_d    = load ? sat[perf_sel] : osat_q;
    overrun_d = overrun_q | drop;
    if (accept && op == PERF_OP_CLR_ALL) overrun_d = 1'b0;
    frozen_d  = frozen_q ^ (accept & (op == PERF_OP_FREEZE));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q    <= '0;
      osat_q    <= 1'b0;
      overrun_q <= 1'b0;
      frozen_q  <= 1'b0;
    end else begin
      data_q    <= data_d;
      osat_q    <= osat_d;
      overrun_q <= overrun_d;
      frozen_q  <= frozen_d;
    end
  end

  assign out_data     = data_q;
  assign out_sat      = osat_q;
  assign perf_overrun = overrun_q;
  assign frozen       = frozen_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Bench for perf_counter_unit: one 32-bit saturating DUT plus 4-bit saturating
// and wrapping DUTs, all driven in lockstep and checked against a counting model.
module tb_perf_counter_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, instr_valid, jump, branch, branch_taken;
  logic       mem_read, mem_write, reg_write, perf, out_ready;
  logic [1:0] perf_op;
  logic [2:0] perf_sel;
  logic [2:0] o_vld, o_sat, o_ovr, o_frz;
  logic [31:0] d0;
  logic [3:0]  d1, d2;

  int checks = 0;
  int errors = 0;

  perf_counter_unit #(.CNT_W(32), .SAT_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .jump(jump), .branch(branch),
    .branch_taken(branch_taken), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .perf(perf), .perf_op(perf_op), .perf_sel(perf_sel),
    .out_ready(out_ready), .out_valid(o_vld[0]), .out_data(d0), .out_sat(o_sat[0]),
    .perf_overrun(o_ovr[0]), .frozen(o_frz[0])
  );

  perf_counter_unit #(.CNT_W(4), .SAT_EN(1'b1)) u_sat4 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .jump(jump), .branch(branch),
    .branch_taken(branch_taken), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .perf(perf), .perf_op(perf_op), .perf_sel(perf_sel),
    .out_ready(out_ready), .out_valid(o_vld[1]), .out_data(d1), .out_sat(o_sat[1]),
    .perf_overrun(o_ovr[1]), .frozen(o_frz[1])
  );

  perf_counter_unit #(.CNT_W(4), .SAT_EN(1'b0)) u_wrap4 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .jump(jump), .branch(branch),
    .branch_taken(branch_taken), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .perf(perf), .perf_op(perf_op), .perf_sel(perf_sel),
    .out_ready(out_ready), .out_valid(o_vld[2]), .out_data(d2), .out_sat(o_sat[2]),
    .perf_overrun(o_ovr[2]), .frozen(o_frz[2])
  );

  // Reference model: plain event counts per DUT configuration.
  int unsigned mw [3]      = '{32, 4, 4};
  bit          msat_en [3] = '{1'b1, 1'b1, 1'b0};
  longint      m_cnt [3][8];
  bit          m_sf  [3][8];
  bit          m_frz [3], m_ovr [3], m_vld [3], m_osat [3];
  longint      m_data [3];

  task automatic model_step();
    bit     acc, is_rd, clr_all, ev [8];
    longint maxv, snap;
    bit     ssat;
    acc     = perf && instr_valid;
    is_rd   = acc && (perf_op == 2'b00 || perf_op == 2'b01);
    clr_all = acc && perf_op == 2'b10;
    ev[0] = 1'b1;
    ev[1] = instr_valid;
    ev[2] = instr_valid && !perf && reg_write && !mem_read && !jump;
    ev[3] = instr_valid && !perf && mem_read;
    ev[4] = instr_valid && !perf && mem_write;
    ev[5] = instr_valid && !perf && branch;
    ev[6] = instr_valid && !perf && branch && branch_taken;
    ev[7] = instr_valid && !perf && jump;
    for (int d = 0; d < 3; d++) begin
      maxv = (longint'(1) << mw[d]) - 1;
      if (!reset) begin
        for (int i = 0; i < 8; i++) begin
          m_cnt[d][i] = 0;
          m_sf[d][i]  = 1'b0;
        end
        m_frz[d] = 0; m_ovr[d] = 0; m_vld[d] = 0; m_osat[d] = 0; m_data[d] = 0;
      end else begin
        snap = m_cnt[d][perf_sel];
        ssat = m_sf[d][perf_sel];
        if (is_rd) begin
          if (!m_vld[d] || out_ready) begin
            m_vld[d] = 1'b1; m_data[d] = snap; m_osat[d] = ssat;
          end else begin
            m_ovr[d] = 1'b1;
          end
        end else if (m_vld[d] && out_ready) begin
          m_vld[d] = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
          if (clr_all || (acc && perf_op == 2'b01 && perf_sel == i)) begin
            m_cnt[d][i] = 0;
            m_sf[d][i]  = 1'b0;
          end else if (ev[i] && !m_frz[d]) begin
            if (m_cnt[d][i] == maxv) begin
              m_sf[d][i] = 1'b1;
              if (!msat_en[d]) m_cnt[d][i] = 0;
            end else begin
              m_cnt[d][i] = m_cnt[d][i] + 1;
            end
          end
        end
        if (clr_all) m_ovr[d] = 1'b0;
        if (acc && perf_op == 2'b11) m_frz[d] = !m_frz[d];
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] act [3];
    act[0] = d0;
    act[1] = {28'd0, d1};
    act[2] = {28'd0, d2};
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({o_vld[d], o_sat[d], o_ovr[d], o_frz[d]} !== {m_vld[d], m_osat[d], m_ovr[d], m_frz[d]}
          || act[d] !== 32'(m_data[d])) begin
        errors++;
        $display("FAIL model_dut%0d t=%0t: got vld=%b data=%0d sat=%b ovr=%b frz=%b, expected vld=%b data=%0d sat=%b ovr=%b frz=%b",
                 d, $time, o_vld[d], act[d], o_sat[d], o_ovr[d], o_frz[d],
                 m_vld[d], m_data[d], m_osat[d], m_ovr[d], m_frz[d]);
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    reset = 1'b1; instr_valid = 0; jump = 0; branch = 0; branch_taken = 0;
    mem_read = 0; mem_write = 0; reg_write = 0; perf = 0; perf_op = 2'b00;
    perf_sel = 3'd0; out_ready = 1'b1;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_cycle();
    clear_inputs();
    step();
  endtask

  task automatic retire(input bit j, input bit br, input bit tk, input bit mr, input bit mwr,
                        input bit rw);
    clear_inputs();
    instr_valid = 1; jump = j; branch = br; branch_taken = tk;
    mem_read = mr; mem_write = mwr; reg_write = rw;
    step();
  endtask

  task automatic perf_cmd(input logic [1:0] op, input logic [2:0] sel, input bit rdy);
    clear_inputs();
    instr_valid = 1; perf = 1; perf_op = op; perf_sel = sel; out_ready = rdy;
    step();
  endtask

  typedef struct {
    logic [2:0] sel;
    longint     data;
    bit         sat;
  } rd_vec_t;

  rd_vec_t rd_tab [7];

  initial begin
    rd_tab[0] = '{3'd1, 12, 1'b0};
    rd_tab[1] = '{3'd3, 3, 1'b0};
    rd_tab[2] = '{3'd4, 2, 1'b0};
    rd_tab[3] = '{3'd5, 4, 1'b0};
    rd_tab[4] = '{3'd6, 1, 1'b0};
    rd_tab[5] = '{3'd7, 1, 1'b0};
    rd_tab[6] = '{3'd2, 2, 1'b0};

    clear_inputs();
    reset = 1'b0; step();
    reset = 1'b0; step();
    chk("reset_valid", o_vld[0], 0);
    chk("reset_data", d0, 0);
    chk("reset_ovr_frz", {o_ovr[0], o_frz[0]}, 0);

    // Ten idle cycles then read the cycle counter.
    for (int i = 0; i < 10; i++) idle_cycle();
    perf_cmd(2'b00, 3'd0, 1'b1);
    chk("cycles_data", d0, 10);
    chk("cycles_valid", o_vld[0], 1);
    chk("cycles_sat", o_sat[0], 0);
    perf_cmd(2'b10, 3'd0, 1'b1);
    chk("clr_all_consumes", o_vld[0], 0);

    // Instruction mix: 3 lw, 2 sw, 4 beq (1 taken), 1 jal, 2 add.
    for (int i = 0; i < 3; i++) retire(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 2; i++) retire(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) retire(0, 1, (i == 2), 0, 0, 0);
    retire(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) retire(0, 0, 0, 0, 0, 1);
    foreach (rd_tab[k]) begin
      perf_cmd(2'b00, rd_tab[k].sel, 1'b1);
      chk($sformatf("mix_sel%0d_data", rd_tab[k].sel), d0, rd_tab[k].data);
      chk($sformatf("mix_sel%0d_sat", rd_tab[k].sel), o_sat[0], rd_tab[k].sat);
      idle_cycle();
    end

    // Read-and-clear of loads with a load flagged in the same cycle.
    clear_inputs();
    instr_valid = 1; perf = 1; perf_op = 2'b01; perf_sel = 3'd3; mem_read = 1; reg_write = 1;
    step();
    chk("rdclr_old", d0, 3);
    idle_cycle();
    perf_cmd(2'b00, 3'd3, 1'b1);
    chk("rdclr_after", d0, 0);
    idle_cycle();

    // Back-pressure: second read dropped, overrun set, then cleared by clear-all.
    perf_cmd(2'b00, 3'd4, 1'b0);
    chk("ovr_first", d0, 2);
    perf_cmd(2'b00, 3'd7, 1'b0);
    chk("ovr_stable", d0, 2);
    chk("ovr_set", o_ovr[0], 1);
    perf_cmd(2'b10, 3'd0, 1'b0);
    chk("ovr_cleared", o_ovr[0], 0);
    chk("ovr_valid_kept", o_vld[0], 1);
    idle_cycle();
    chk("ovr_consumed", o_vld[0], 0);

    // Freeze: retired counter only sees the freezing instruction.
    perf_cmd(2'b11, 3'd0, 1'b1);
    chk("frz_on", o_frz[0], 1);
    for (int i = 0; i < 5; i++) retire(0, 0, 0, 0, 0, 1);
    perf_cmd(2'b11, 3'd0, 1'b1);
    chk("frz_off", o_frz[0], 0);
    perf_cmd(2'b00, 3'd1, 1'b1);
    chk("frz_retired", d0, 1);
    idle_cycle();

    // Saturation vs wrap on the 4-bit instances.
    perf_cmd(2'b10, 3'd0, 1'b1);
    for (int i = 0; i < 20; i++) retire(0, 0, 0, 0, 0, 1);
    perf_cmd(2'b00, 3'd1, 1'b1);
    chk("sat32_data", d0, 20);
    chk("sat4_data", d1, 15);
    chk("sat4_flag", o_sat[1], 1);
    chk("wrap4_data", d2, 4);
    chk("wrap4_flag", o_sat[2], 1);
    idle_cycle();

    // Reset while a snapshot is held.
    perf_cmd(2'b00, 3'd0, 1'b0);
    chk("hold_valid", o_vld[0], 1);
    clear_inputs();
    reset = 1'b0;
    step();
    chk("hold_reset_valid", o_vld[0], 0);
    chk("hold_reset_data", d0, 0);
    idle_cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      clear_inputs();
      reset        = ($urandom_range(0, 299) != 0);
      instr_valid  = ($urandom_range(0, 3) != 0);
      jump         = ($urandom_range(0, 5) == 0);
      branch       = ($urandom_range(0, 4) == 0);
      branch_taken = ($urandom_range(0, 1) == 0);
      mem_read     = ($urandom_range(0, 3) == 0);
      mem_write    = ($urandom_range(0, 4) == 0);
      reg_write    = ($urandom_range(0, 1) == 0);
      perf         = ($urandom_range(0, 5) == 0);
      perf_op      = 2'($urandom_range(0, 3));
      perf_sel     = 3'($urandom_range(0, 7));
      out_ready    = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/perf_counter_unit.md
Name: perf_counter_unit

Overview:
- Consumer of the main decoder's control outputs. Counts retired-instruction classes and cycles in eight saturating counters.
- Services the perf instruction (opcode 6'b110011) by snapshotting, clearing or freezing the counters.
- Snapshots are presented on a valid/ready readout port to the debug/display logic.
- Sits beside the datapath in the single-cycle core; sees one decoded instruction per cycle.

Parameters:
- CNT_W, 32, width of each counter and of out_data.
- SAT_EN, 1, 1 = counters saturate at all-ones; 0 = counters wrap.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- instr_valid  input  1  an instruction retires this cycle
- jump  input  1  decoder jump (j, jal)
- branch  input  1  decoder branch (beq)
- branch_taken  input  1  datapath branch condition true
- mem_read  input  1  decoder mem_read (lw)
- mem_write  input  1  decoder mem_write (sw)
- reg_write  input  1  decoder reg_write
- perf  input  1  decoder perf strobe
- perf_op  input  2  instruction bits [17:16]: 00 read, 01 read-and-clear, 10 clear-all, 11 freeze-toggle
- perf_sel  input  3  instruction bits [20:18]: counter index
- out_ready  input  1  consumer accepts out_data
- out_valid  output  1  snapshot available
- out_data  output  CNT_W  snapshot value
- out_sat  output  1  selected counter had saturated/wrapped at snapshot
- perf_overrun  output  1  sticky: a read was dropped
- frozen  output  1  counters halted

Behaviour:
- Reset (reset==0 at posedge): all counters 0, all sat flags 0, out_valid 0, out_data 0, out_sat 0, perf_overrun 0, frozen 0, FSM to IDLE. Reset applies even with a read in HOLD; the pending snapshot is lost.
- Counter indices:
  - 0 cycles: every cycle.
  - 1 retired: instr_valid.
  - 2 alu: instr_valid & reg_write & !mem_read & !jump.
  - 3 load: instr_valid & mem_read.
  - 4 store: instr_valid & mem_write.
  - 5 branch: instr_valid & branch.
  - 6 taken: instr_valid & branch & branch_taken.
  - 7 jump: instr_valid & jump.
- A perf instruction counts only in counters 0 and 1.
- Increment is +1 per qualifying cycle. SAT_EN=1: at all-ones the counter holds and its sat flag sets. SAT_EN=0: it wraps to 0 and its sat flag sets. Sat flags clear only on a clear of that counter, or on reset.
- When frozen=1, no counter changes except by a clear; perf ops are still serviced.
- A perf op is accepted when perf & instr_valid. perf without instr_valid is ignored.
- Read (00) / read-and-clear (01):
  - Snapshot is counter[perf_sel] and its sat flag as held at the start of the accepting cycle N, i.e. pre-increment.
  - The snapshot appears on out_data/out_sat with out_valid=1 at cycle N+1; latency is 1.
  - For 01, counter[perf_sel] and its sat flag are 0 at N+1; any same-cycle increment is discarded.
- Clear-all (10): every counter and sat flag 0 at N+1; perf_overrun cleared; no output produced; out_valid unaffected.
- Freeze-toggle (11): frozen inverts at N+1; counter 0 still counts cycle N if frozen was 0 during N.
- FSM:
  - IDLE: out_valid=0. An accepted read loads the snapshot and moves to HOLD.
  - HOLD: out_valid=1; out_data/out_sat are stable until the handshake.
    - out_ready=1 with no new read: go to IDLE.
    - out_ready=1 with a new accepted read in the same cycle: load the new snapshot and stay in HOLD (back-to-back).
    - out_ready=0 with a new accepted read: drop it and set perf_overrun. The clear side effect of a dropped op 01 still occurs.
- A clear, freeze or read side effect on the same counter as a pending increment takes priority over the increment.

Decomposition:
- Package perf_pkg:
  - counter index constants CNT_CYCLES..CNT_JUMP (0..7);
  - PERF_OP_READ/READ_CLR/CLR_ALL/FREEZE encodings;
  - OPC_PERF = 6'b110011.
- Sub-module perf_event_counter (CNT_W, SAT_EN): inputs inc, clr, hold; outputs count, sat. Instantiated 8 times.
- Top level holds event decode, the op decode and the IDLE/HOLD readout FSM.

Test Plan:
- Reset low 2 cycles, then run 10 cycles idle → read sel 0 at cycle 10 returns out_data=10 at cycle 11; out_valid=1, out_sat=0.
- Retire 3 lw, 2 sw, 4 beq with 1 taken, 1 jal → reads of sel 3/4/5/6/7 return 3/2/4/1/1. Sel 2 excludes the jal and the loads.
- Read-and-clear sel 3 while a lw retires in the same cycle → snapshot is the old value; the next read of sel 3 returns 0.
- Hold out_ready=0 and issue 2 reads → first snapshot stays stable, perf_overrun=1; clear-all → perf_overrun=0.
- CNT_W=4, SAT_EN=1: retire 20 instructions → sel 1 reads 15 with out_sat=1. Repeat with SAT_EN=0 → reads 4 with out_sat=1.
- Freeze, retire 5 instructions, unfreeze → sel 1 unchanged across the freeze. Assert reset in HOLD → out_valid=0 the next cycle.
